// File: rtl/modn_updown_counter.sv
// ---------------------------------------------------------------------------
// modn_updown_counter
// WIDTH-bit modulo-M up/down counter with runtime-programmable modulus.
// A modulus request of 0 selects the full 2^WIDTH range. The block provides
// count enable, direction, a synchronous clamped load, a combinational
// terminal count (tc) for zero-latency cascading, and a registered one-cycle
// wrap pulse.
//
// Optional feature macro: MODN_CNT_SHADOW_EN
//   defined   -> modulus is captured into a shadow register only on a wrap
//                step or a load, so a period in progress finishes at its old
//                length; the shadow resets to DEFAULT_MOD.
//   undefined -> modulus is used directly every cycle (default build).
// ---------------------------------------------------------------------------
module modn_updown_counter #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_MOD = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // M-1 for a modulus of 0 (full range); WIDTH+1 bits so 2^WIDTH fits.
  localparam logic [WIDTH:0] FULL_MAX = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic [WIDTH-1:0] w_modSrc;
  logic [WIDTH:0]   w_modMax;
  logic [WIDTH:0]   w_loadMax;
  logic [WIDTH:0]   w_countExt;
  logic [WIDTH:0]   w_loadValExt;
  logic [WIDTH-1:0] w_loadClamp;
  logic             w_upWrap;
  logic             w_dnWrap;
  logic             w_tc;
  logic [WIDTH-1:0] w_nextCount;

`ifdef MODN_CNT_SHADOW_EN
  logic [WIDTH-1:0] r_modShadow;

  // Shadow modulus: refreshed only at period boundaries (wrap step) or on load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_modShadow <= WIDTH'(DEFAULT_MOD);
    end else if (load || w_tc) begin
      r_modShadow <= modulus;
    end
  end

  assign w_modSrc = r_modShadow;
`else
  // DEFAULT_MOD only seeds the shadow register; fold it into an unused net so
  // the shadow-less build still consumes the parameter.
  logic w_unusedDefaultMod;
  assign w_unusedDefaultMod = ^(WIDTH'(DEFAULT_MOD));

  assign w_modSrc = modulus;
`endif

  // Upper bound M-1 of the legal range for stepping, and for the load clamp.
  // The load clamp always sees the live modulus input: with the shadow
  // enabled the shadow takes that same value on the load edge.
  always_comb begin
    w_modMax  = (w_modSrc == '0) ? FULL_MAX : ({1'b0, w_modSrc} - ONE_EXT);
    w_loadMax = (modulus  == '0) ? FULL_MAX : ({1'b0, modulus}  - ONE_EXT);
  end

  // Wrap detection; the inequalities also pull an out-of-range count back
  // into range after the modulus is reduced below it.
  always_comb begin
    w_countExt   = {1'b0, r_count};
    w_loadValExt = {1'b0, load_val};
    w_upWrap     = (w_countExt >= w_modMax);
    w_dnWrap     = (r_count == '0) || (w_countExt > w_modMax);
    w_tc         = en && !load && (up_dn ? w_upWrap : w_dnWrap);
    w_loadClamp  = (w_loadValExt > w_loadMax) ? w_loadMax[WIDTH-1:0] : load_val;
  end

  // Next-count selection: load beats enable, enable beats hold.
  always_comb begin
    w_nextCount = r_count;
    if (load) begin
      w_nextCount = w_loadClamp;
    end else if (en) begin
      if (up_dn) begin
        w_nextCount = w_upWrap ? '0 : (r_count + WIDTH'(1));
      end else begin
        w_nextCount = w_dnWrap ? w_modMax[WIDTH-1:0] : (r_count - WIDTH'(1));
      end
    end
  end

  // Count register and the wrap pulse, which is simply tc delayed one edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_nextCount;
      r_wrap  <= w_tc;
    end
  end

  assign count = r_count;
  assign tc    = w_tc;
  assign wrap  = r_wrap;

endmodule
